// File: rtl/carfield_domain_pwr_seq.sv
// Purpose: sequence Carfield domains up/down one at a time (clock -> reset -> isolation), round-robin between requests.
// Latency: up = 1 + ClkSettleCycles + RstHoldCycles + 1 + ack wait; down = 1 + ack wait + 2; one IDLE cycle between sequences.
// Backpressure: none; requests are levels and stay pending until served. Optional ack timeout: CARFIELD_PWRSEQ_TIMEOUT_EN.
module carfield_domain_pwr_seq #(
  parameter int unsigned            NumDomains      = 6,
  parameter logic [NumDomains-1:0]  DomainMask      = '1,
  parameter int unsigned            ClkSettleCycles = 4,
  parameter int unsigned            RstHoldCycles   = 8,
  parameter int unsigned            TimeoutCycles   = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumDomains-1:0]         req_on_i,
  input  logic [NumDomains-1:0]         err_clr_i,
  input  logic [NumDomains-1:0]         isolated_i,
  output logic [NumDomains-1:0]         clk_en_o,
  output logic [NumDomains-1:0]         dom_rst_o,
  output logic [NumDomains-1:0]         isolate_o,
  output logic [NumDomains-1:0]         on_o,
  output logic [NumDomains-1:0]         err_o,
  output logic                          busy_o,
  output logic [$clog2(NumDomains)-1:0] active_o
);

  localparam int unsigned IdxW    = $clog2(NumDomains);
  localparam int unsigned MaxA    = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
  localparam int unsigned MaxWait = (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  localparam logic [CntW-1:0] SettleLast  = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {IDLE, UP_CLK, UP_RST, UP_ISO, DN_ISO, DN_RST, DN_CLK} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IdxW-1:0]        ptr_q, ptr_d, ptr_nxt;
  logic                   busy_q;
  logic [NumDomains-1:0]  clk_en_q, clk_en_d;
  logic [NumDomains-1:0]  dom_rst_q, dom_rst_d;
  logic [NumDomains-1:0]  isolate_q, isolate_d;
  logic [NumDomains-1:0]  on_q, on_d;
  logic [NumDomains-1:0]  pend;
  logic                   grant_vld, hi_vld, timeout;
  logic [IdxW-1:0]        grant_idx, hi_idx;

  // A domain needs service when its request differs from its state and it is not parked in error.
  assign pend    = DomainMask & (req_on_i ^ on_q) & ~err_o;
  assign ptr_nxt = (idx_q == IdxW'(NumDomains - 1)) ? '0 : idx_q + 1'b1;

  // Round-robin pick: lowest pending index at/after the pointer, else lowest pending overall (wrap).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    hi_vld    = 1'b0;
    hi_idx    = '0;
    for (int k = int'(NumDomains) - 1; k >= 0; k--) begin
      if (pend[k]) begin
        grant_vld = 1'b1;
        grant_idx = IdxW'(k);
      end
      if (pend[k] && (IdxW'(k) >= ptr_q)) begin
        hi_vld = 1'b1;
        hi_idx = IdxW'(k);
      end
    end
    if (hi_vld) grant_idx = hi_idx;
  end

  // Next state, wait counter and the next value of the active domain's control bits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    clk_en_d  = clk_en_q;
    dom_rst_d = dom_rst_q;
    isolate_d = isolate_q;
    on_d      = on_q;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          idx_d = grant_idx;
          cnt_d = '0;
          if (req_on_i[grant_idx]) begin
            state_d             = UP_CLK;
            clk_en_d[grant_idx] = 1'b1;
          end else begin
            state_d              = DN_ISO;
            isolate_d[grant_idx] = 1'b1;
            on_d[grant_idx]      = 1'b0;
          end
        end
      end
      UP_CLK: begin
        if (cnt_q == SettleLast) begin
          state_d          = UP_RST;
          cnt_d            = '0;
          dom_rst_d[idx_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UP_RST: begin
        if (cnt_q == HoldLast) begin
          state_d          = UP_ISO;
          cnt_d            = '0;
          isolate_d[idx_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UP_ISO: begin
        if (!isolated_i[idx_q]) begin
          state_d     = IDLE;
          cnt_d       = '0;
          ptr_d       = ptr_nxt;
          on_d[idx_q] = 1'b1;
        end
`ifdef CARFIELD_PWRSEQ_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DN_ISO: begin
        if (isolated_i[idx_q]) begin
          state_d          = DN_RST;
          cnt_d            = '0;
          dom_rst_d[idx_q] = 1'b1;
        end
`ifdef CARFIELD_PWRSEQ_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DN_RST: begin
        state_d         = DN_CLK;
        cnt_d           = '0;
        clk_en_d[idx_q] = 1'b0;
      end
      DN_CLK: begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = ptr_nxt;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A stuck ack drops the domain straight back to its safe, fully-off state.
    if (timeout) begin
      state_d          = IDLE;
      cnt_d            = '0;
      ptr_d            = ptr_nxt;
      isolate_d[idx_q] = 1'b1;
      dom_rst_d[idx_q] = 1'b1;
      clk_en_d[idx_q]  = 1'b0;
      on_d[idx_q]      = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      clk_en_q  <= '0;
      dom_rst_q <= '1;
      isolate_q <= '1;
      on_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      busy_q    <= (state_d != IDLE);
      clk_en_q  <= clk_en_d;
      dom_rst_q <= dom_rst_d;
      isolate_q <= isolate_d;
      on_q      <= on_d;
    end
  end

`ifdef CARFIELD_PWRSEQ_TIMEOUT_EN
  logic [NumDomains-1:0] err_q, err_set;

  // Error flag for the domain whose ack timed out this cycle.
  always_comb begin
    err_set = '0;
    if (timeout) err_set[idx_q] = 1'b1;
  end

  // Sticky error; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= (err_q & ~err_clr_i) | err_set;
  end

  assign err_o = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = ^err_clr_i;
  assign err_o          = '0;
`endif

  assign clk_en_o  = clk_en_q;
  assign dom_rst_o = dom_rst_q;
  assign isolate_o = isolate_q;
  assign on_o      = on_q;
  assign busy_o    = busy_q;
  assign active_o  = idx_q;

endmodule

// File: tb/tb_carfield_domain_pwr_seq.sv
// Bench for carfield_domain_pwr_seq: randomized request bursts and ack delays against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_carfield_domain_pwr_seq;

  localparam int TO = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] req_on_i, err_clr_i, isolated_i;
  logic [3:0] clk_en_o, dom_rst_o, isolate_o, on_o, err_o;
  logic       busy_o;
  logic [1:0] active_o;

  logic [3:0] m_clk, m_rst, m_iso, m_on, m_err;
  logic       m_unused_busy;
  logic [1:0] m_unused_act;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Domain models: isolated_i follows isolate_o after dly[i] cycles unless stuck.
  int         dly [4];
  logic [7:0] hist[4];
  logic [3:0] stuck;

  // Expected settled per-domain outputs and arbitration pointer.
  logic [3:0] x_clk, x_rst, x_iso, x_on, x_err;
  int         ptr;

  always #5 clk_i = ~clk_i;

  carfield_domain_pwr_seq #(
    .NumDomains(4), .DomainMask(4'b1111), .ClkSettleCycles(4), .RstHoldCycles(8), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_on_i(req_on_i), .err_clr_i(err_clr_i), .isolated_i(isolated_i),
    .clk_en_o(clk_en_o), .dom_rst_o(dom_rst_o), .isolate_o(isolate_o), .on_o(on_o), .err_o(err_o),
    .busy_o(busy_o), .active_o(active_o)
  );

  // Masked copy: domain 3 must never move; its own isolation output acks itself.
  carfield_domain_pwr_seq #(
    .NumDomains(4), .DomainMask(4'b0111), .ClkSettleCycles(4), .RstHoldCycles(8), .TimeoutCycles(TO)
  ) dut_m (
    .clk_i(clk_i), .rst_i(rst_i), .req_on_i(req_on_i), .err_clr_i(err_clr_i), .isolated_i(m_iso),
    .clk_en_o(m_clk), .dom_rst_o(m_rst), .isolate_o(m_iso), .on_o(m_on), .err_o(m_err),
    .busy_o(m_unused_busy), .active_o(m_unused_act)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    for (int j = 0; j < 4; j++) begin
      hist[j]       = {hist[j][6:0], isolate_o[j]};
      isolated_i[j] = stuck[j] ? 1'b1 : hist[j][dly[j]];
    end
  endtask

  task automatic check_all(input logic [3:0] e_clk, input logic [3:0] e_rst, input logic [3:0] e_iso,
                           input logic [3:0] e_on, input logic [3:0] e_err, input logic e_busy, input int e_act);
    chk("clk_en", 8'(clk_en_o), 8'(e_clk));
    chk("dom_rst", 8'(dom_rst_o), 8'(e_rst));
    chk("isolate", 8'(isolate_o), 8'(e_iso));
    chk("on", 8'(on_o), 8'(e_on));
    chk("err", 8'(err_o), 8'(e_err));
    chk("busy", 8'(busy_o), 8'(e_busy));
    if (e_busy) chk("active", 8'(active_o), 8'(e_act));
    chk("masked_dom3", 8'({m_clk[3], m_rst[3], m_iso[3], m_on[3], m_err[3]}), 8'b0000_1100);
  endtask

  task automatic check_idle();
    check_all(x_clk, x_rst, x_iso, x_on, x_err, 1'b0, 0);
  endtask

  // One sequence of domain i whose first busy cycle is the current sample (k = 0).
  // kind 0 = power-up, 1 = power-down. drop_k releases the request at that offset; stop_k ends early.
  task automatic run_seq(input int i, input int kind, input int drop_k, input int stop_k);
    int         d, len, last;
    bit         tmo;
    logic [3:0] e_clk, e_rst, e_iso, e_on, e_err;
    logic       e_busy;
    d   = dly[i];
    tmo = 1'b0;
`ifdef CARFIELD_PWRSEQ_TIMEOUT_EN
    tmo = (kind == 0) && stuck[i];
`endif
    if (kind == 1)  len = d + 3;
    else if (tmo)   len = 12 + TO;
    else            len = 13 + d;
    last = (stop_k >= 0) ? stop_k : len;
    e_clk = x_clk; e_rst = x_rst; e_iso = x_iso; e_on = x_on; e_err = x_err;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) tick();
      if (k == drop_k) req_on_i[i] = 1'b0;
      e_busy = (k < len);
      if (kind == 1) begin
        e_iso[i] = 1'b1;
        e_on[i]  = 1'b0;
        e_rst[i] = (k >= d + 1);
        e_clk[i] = (k < d + 2);
      end else if (tmo) begin
        e_clk[i] = (k < len);
        e_rst[i] = (k < 4) || (k >= len);
        e_iso[i] = (k < 12) || (k >= len);
        e_on[i]  = 1'b0;
        e_err[i] = (k >= len);
      end else begin
        e_clk[i] = 1'b1;
        e_rst[i] = (k < 4);
        e_iso[i] = (k < 12);
        e_on[i]  = (k >= len);
      end
      check_all(e_clk, e_rst, e_iso, e_on, e_err, e_busy, i);
    end
    if (stop_k < 0) begin
      x_clk = e_clk; x_rst = e_rst; x_iso = e_iso; x_on = e_on; x_err = e_err;
    end
  endtask

  // Apply a request vector and expect every resulting sequence in round-robin order, back to back.
  task automatic burst(input logic [3:0] r);
    logic [3:0] pend;
    int         idx;
    req_on_i = r;
    for (int n = 0; n < 8; n++) begin
      pend = (req_on_i ^ x_on) & ~x_err;
      if (pend == 4'b0000) break;
      idx = -1;
      for (int s = 0; s < 4; s++)
        if (idx < 0 && pend[(ptr + s) % 4]) idx = (ptr + s) % 4;
      tick();
      run_seq(idx, req_on_i[idx] ? 0 : 1, -1, -1);
      ptr = (idx + 1) % 4;
    end
    tick(); check_idle();
    tick(); check_idle();
  endtask

  task automatic model_reset();
    x_clk = 4'b0000; x_rst = 4'b1111; x_iso = 4'b1111; x_on = 4'b0000; x_err = 4'b0000;
    ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time (passed %0d of %0d)", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; req_on_i = 4'b0000; err_clr_i = 4'b0000; stuck = 4'b0000;
    isolated_i = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      hist[j] = 8'hFF;
      dly[j]  = int'($urandom_range(1, 5));
    end
    dly[0] = 3;
    model_reset();

    // Reset values.
    repeat (3) tick();
    check_all(4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 0);
    chk("active_rst", 8'(active_o), 8'd0);
    rst_i = 1'b0;
    tick(); check_idle();

    // Single power-up of domain 0 (ack 3 cycles after isolation release), then power-down.
    burst(4'b0001);
    burst(4'b0000);
    // Cycle domain 3 so the pointer wraps back to 0.
    burst(4'b1000);
    burst(4'b0000);

    // Round-robin: all four at once, all off, domain 1 alone, then 0 and 2 together.
    burst(4'b1111);
    burst(4'b0000);
    burst(4'b0010);
    burst(4'b0111);

    // Request for domain 1 dropped during its reset hold: power-up completes, then power-down.
    burst(4'b0101);
    req_on_i = 4'b0111;
    tick();
    run_seq(1, 0, 6, -1);
    ptr = 2;
    burst(req_on_i);

    // Stuck isolation ack on domain 2 power-up.
    burst(4'b0001);
`ifdef CARFIELD_PWRSEQ_TIMEOUT_EN
    stuck[2] = 1'b1;
`endif
    burst(4'b0101);
    repeat (3) begin
      tick(); check_idle();
    end
    err_clr_i = 4'b0100;
    tick();
    err_clr_i = 4'b0000;
    stuck[2]  = 1'b0;
    x_err[2]  = 1'b0;
    check_idle();
    burst(req_on_i);

    // Randomized request patterns.
    for (int r = 0; r < 6; r++) burst(4'($urandom_range(0, 15)));

    // Reset in the middle of a power-up.
    burst(4'b0000);
    req_on_i = 4'b0001;
    tick();
    run_seq(0, 0, -1, 6);
    rst_i = 1'b1;
    tick();
    check_all(4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 0);
    chk("active_rst", 8'(active_o), 8'd0);
    model_reset();
    req_on_i = 4'b0000;
    rst_i    = 1'b0;
    tick(); check_idle();
    burst(4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/carfield_domain_pwr_seq.md
# carfield_domain_pwr_seq

Sequencer that brings Carfield's gateable domains up and down one at a time: safety island, security island, PULP cluster, Spatz cluster, L2 ports and the peripheral subsystem. It sits between the platform control registers (per-domain on/off request bits) and each domain's clock gate, reset and AXI isolation cells. It applies a fixed clock → reset → isolation ordering and round-robin arbitrates between concurrent requests.

## Interface
- NumDomains, 6, number of sequenced domains (N)
- DomainMask, '1, per-domain compile-time enable; masked domains are never sequenced
- ClkSettleCycles, 4, cycles between clock enable and reset release (≥1)
- RstHoldCycles, 8, cycles between reset release and isolation release (≥1)
- TimeoutCycles, 256, ack wait limit in cycles (only with timeout macro)

Clock and reset: one clock, `clk_i`. Reset is synchronous and active-high, `rst_i`.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_on_i  in  N  level; requested state per domain (1 = on)
- err_clr_i  in  N  single-cycle pulse; clears err_o[i]
- isolated_i  in  N  isolation status from domain (1 = isolated)
- clk_en_o  out  N  domain clock-gate enable
- dom_rst_o  out  N  domain reset, active-high
- isolate_o  out  N  isolation request (1 = isolate)
- on_o  out  N  domain fully up
- err_o  out  N  sticky sequencing error
- busy_o  out  1  sequence in progress
- active_o  out  $clog2(N)  index of the domain being sequenced (valid while busy_o)

## Operation
- Reset values: clk_en_o=0, dom_rst_o='1, isolate_o='1, on_o=0, err_o=0, busy_o=0, active_o=0, round-robin pointer=0. Reset mid-sequence aborts the sequence and returns all outputs to these values on the next edge.
- Pending: pend[i] = DomainMask[i] & (req_on_i[i] != on_o[i]) & ~err_o[i].
- Arbitration in IDLE: grant the first pending index at or after the pointer, wrapping N-1→0. On completion of that domain's sequence, the pointer becomes (granted+1) mod N.
- FSM states: IDLE, UP_CLK, UP_RST, UP_ISO, DN_ISO, DN_RST, DN_CLK.
- IDLE → UP_CLK on a grant with req_on_i=1; IDLE → DN_ISO on a grant with req_on_i=0.
- UP_CLK: clk_en_o[i]=1. Wait ClkSettleCycles, then go to UP_RST.
- UP_RST: dom_rst_o[i]=0. Wait RstHoldCycles, then go to UP_ISO.
- UP_ISO: isolate_o[i]=0. Wait for isolated_i[i]=0, then set on_o[i]=1 and go to IDLE.
- DN_ISO: isolate_o[i]=1 and on_o[i]=0. Wait for isolated_i[i]=1, then go to DN_RST.
- DN_RST: dom_rst_o[i]=1 for one cycle, then go to DN_CLK.
- DN_CLK: clk_en_o[i]=0 for one cycle, then go to IDLE.
- A request change mid-sequence does not abort the sequence. It is re-evaluated as pending after return to IDLE.
- Only outputs of the active domain change. Masked domains hold their reset values permanently.
- err_o is set (timeout) and err_clr_i is pulsed in the same cycle: set wins.
- The wait counter is wide enough for max(ClkSettleCycles, RstHoldCycles, TimeoutCycles). It is cleared on every state entry.

## Timing
- All outputs are registered. A grant is taken in the IDLE cycle, and state outputs change on the following edge.
- Power-up latency from the grant edge to on_o=1 is 1 + ClkSettleCycles + RstHoldCycles + 1 + ack-wait cycles.
- Power-down: isolate_o rises one cycle after the grant, dom_rst_o rises one cycle after the isolation ack is sampled, and clk_en_o falls one cycle after that.
- busy_o=1 from the first state after IDLE through the last cycle before re-entering IDLE.
- At least one IDLE cycle separates consecutive sequences.

## Configuration
- `CARFIELD_PWRSEQ_TIMEOUT_EN` defined:
  - UP_ISO and DN_ISO count wait cycles.
  - On reaching TimeoutCycles, set err_o[i]=1, force isolate_o[i]=1, dom_rst_o[i]=1, clk_en_o[i]=0 and on_o[i]=0 on the next edge, then return to IDLE.
  - The domain is excluded from arbitration until err_clr_i[i].
- Macro undefined:
  - The ack waits are unbounded and err_o is tied to 0.
  - err_clr_i is ignored.

## Test plan
Bench parameters for all scenarios: N=4, ClkSettleCycles=4, RstHoldCycles=8, TimeoutCycles=16.
- Single power-up:
  - Stimulus: req_on_i=4'b0001; isolated_i[0] falls 3 cycles after isolate_o[0] falls.
  - Required: clk_en_o[0] rises 1 cycle after the grant, dom_rst_o[0] falls 4 cycles later, isolate_o[0] falls 8 cycles after that, on_o[0]=1 one cycle after the ack.
- Power-down ordering:
  - Stimulus: domain 0 on, then req_on_i[0]=0.
  - Required: isolate_o[0]=1 first; dom_rst_o[0]=1 one cycle after the isolated_i[0]=1 ack; clk_en_o[0]=0 one cycle later; on_o[0]=0 throughout.
- Round-robin:
  - Stimulus: req_on_i=4'b1111 in one cycle, pointer at 0.
  - Required: active_o sequences 0,1,2,3. A second burst asserted at 4'b0101 after domain 1 has been served is granted 2 then 0.
- Timeout (macro defined):
  - Stimulus: isolated_i[2] held at 1 after isolate_o[2]=0.
  - Required: err_o[2]=1 after 16 cycles; domain 2 returns to isolate=1, rst=1, clk_en=0; no re-grant while req_on_i[2]=1.
  - Follow-up: an err_clr_i[2] pulse re-enables arbitration for domain 2.
- Mask and mid-sequence change:
  - Stimulus: DomainMask=4'b0111 with req_on_i[3]=1.
  - Required: domain 3 outputs stay at their reset values.
  - Stimulus: req_on_i[1] dropped during UP_RST.
  - Required: the power-up completes (on_o[1]=1), then a power-down of domain 1 starts after one IDLE cycle.
- Reset mid-sequence:
  - Stimulus: rst_i asserted during UP_RST of domain 0.
  - Required: all outputs at reset values on the next edge and busy_o=0.
